dmem_access: RTL and testbench

Memory-stage load/store unit between the pipeline's M-stage outputs (effective address, store data) and a synchronous data RAM with a req/ack handshake. It handles MIPS byte/halfword/word sizing, little-endian lane steering, sign/zero extension and alignment checks. It holds the pipeline with `memstallM` until the RAM acknowledges, and returns formatted load data to the M/W pipeline register input.

---
 rtl/dmem_access_if.sv | 26 ++
 rtl/dmem_access.sv | 179 +++++++++++++++++
 tb/tb_dmem_access.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_access_if.sv
// dmem_access_if: request/acknowledge bus between the memory-stage
// load/store unit (master) and a synchronous data RAM (slave).
//
// Handshake: the master raises ram_req together with ram_we/ram_be/
// ram_addr/ram_wdata and holds all of them stable until it samples
// ram_ack=1 on a rising clock edge. ram_rdata is valid in that same ack
// cycle. ram_ack outside an outstanding request is ignored.
interface dmem_access_if;
  logic        ram_req;
  logic        ram_we;
  logic [3:0]  ram_be;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_ack;
  logic [31:0] ram_rdata;

  modport master (
    output ram_req, ram_we, ram_be, ram_addr, ram_wdata,
    input  ram_ack, ram_rdata
  );

  modport slave (
    input  ram_req, ram_we, ram_be, ram_addr, ram_wdata,
    output ram_ack, ram_rdata
  );
endinterface

// File: rtl/dmem_access.sv
// dmem_access: MIPS memory-stage load/store unit. Sizes byte/half/word
// accesses, steers little-endian lanes, checks alignment, stalls the
// pipeline until the RAM acknowledges and returns the formatted load
// result registered in readdataM.
//
// Optional build macro DMEM_TIMEOUT_EN: adds a BUSY watchdog that aborts
// an access after TIMEOUT cycles without ack and pulses buserrM.
module dmem_access #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memenM,
  input  logic        memwriteM,
  input  logic [1:0]  memsizeM,
  input  logic        memsignM,
  input  logic [31:0] aluoutM,
  input  logic [31:0] writedataM,
  output logic [31:0] readdataM,
  output logic        memstallM,
  output logic        adelM,
  output logic        adesM,
  output logic        buserrM,
  output logic [1:0]  dbg_state_o,
  dmem_access_if.master ram
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e      state_q;
  logic        ram_req_q;
  logic        ram_we_q;
  logic [3:0]  ram_be_q;
  logic [31:0] ram_addr_q;
  logic [31:0] ram_wdata_q;
  logic [31:0] readdata_q;
  // Load-format fields captured at issue so formatting does not depend
  // on the pipeline holding its M-stage values.
  logic [1:0]  size_q;
  logic        sign_q;
  logic [1:0]  lane_q;

  logic        misaligned;
  logic        issue;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_fmt;

  // Alignment check and request steering from the live M-stage inputs.
  always_comb begin
    misaligned = 1'b0;
    be_d       = 4'b1111;
    wdata_d    = writedataM;
    case (memsizeM)
      2'b00: begin
        be_d    = 4'b0001 << aluoutM[1:0];
        wdata_d = {4{writedataM[7:0]}};
      end
      2'b01: begin
        misaligned = aluoutM[0];
        be_d       = aluoutM[1] ? 4'b1100 : 4'b0011;
        wdata_d    = {2{writedataM[15:0]}};
      end
      default: begin
        misaligned = (aluoutM[1:0] != 2'b00);
      end
    endcase
  end

  assign issue     = (state_q == ST_IDLE) && memenM && !misaligned;
  assign memstallM = issue || (state_q == ST_BUSY);
  assign adelM     = (state_q == ST_IDLE) && memenM && misaligned && !memwriteM;
  assign adesM     = (state_q == ST_IDLE) && memenM && misaligned &&  memwriteM;

  // Lane extraction and sign/zero extension of the returning read data.
  always_comb begin
    ld_byte = ram.ram_rdata[{lane_q, 3'b000} +: 8];
    ld_half = lane_q[1] ? ram.ram_rdata[31:16] : ram.ram_rdata[15:0];
    case (size_q)
      2'b00:   ld_fmt = {{24{sign_q & ld_byte[7]}}, ld_byte};
      2'b01:   ld_fmt = {{16{sign_q & ld_half[15]}}, ld_half};
      default: ld_fmt = ram.ram_rdata;
    endcase
  end

`ifdef DMEM_TIMEOUT_EN
  logic [31:0] to_cnt_q;
  logic        buserr_q;
  assign buserrM = buserr_q;
`else
  // No watchdog: BUSY waits for ack indefinitely and TIMEOUT has no effect.
  assign buserrM = 1'b0;
  if (TIMEOUT == 0) begin : g_timeout_unused
  end
`endif

  // Access FSM: issue in IDLE, wait for ack in BUSY, release in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ram_req_q   <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_be_q    <= 4'b0000;
      ram_addr_q  <= 32'h0;
      ram_wdata_q <= 32'h0;
      readdata_q  <= 32'h0;
      size_q      <= 2'b00;
      sign_q      <= 1'b0;
      lane_q      <= 2'b00;
`ifdef DMEM_TIMEOUT_EN
      to_cnt_q    <= 32'h0;
      buserr_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (issue) begin
            ram_req_q   <= 1'b1;
            ram_we_q    <= memwriteM;
            ram_be_q    <= be_d;
            ram_addr_q  <= {aluoutM[31:2], 2'b00};
            ram_wdata_q <= wdata_d;
            size_q      <= memsizeM;
            sign_q      <= memsignM;
            lane_q      <= aluoutM[1:0];
`ifdef DMEM_TIMEOUT_EN
            to_cnt_q    <= 32'h0;
`endif
            state_q     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (ram.ram_ack) begin
            if (!ram_we_q) readdata_q <= ld_fmt;
            ram_req_q <= 1'b0;
            ram_we_q  <= 1'b0;
            ram_be_q  <= 4'b0000;
            state_q   <= ST_DONE;
          end
`ifdef DMEM_TIMEOUT_EN
          else if ((to_cnt_q + 32'd1) >= TIMEOUT) begin
            // Abort: the instruction retires with zero data and a bus error.
            readdata_q <= 32'h0;
            ram_req_q  <= 1'b0;
            ram_we_q   <= 1'b0;
            ram_be_q   <= 4'b0000;
            buserr_q   <= 1'b1;
            state_q    <= ST_DONE;
          end else begin
            to_cnt_q <= to_cnt_q + 32'd1;
          end
`endif
        end
        ST_DONE: begin
`ifdef DMEM_TIMEOUT_EN
          buserr_q <= 1'b0;
`endif
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign readdataM     = readdata_q;
  assign dbg_state_o   = state_q;
  assign ram.ram_req   = ram_req_q;
  assign ram.ram_we    = ram_we_q;
  assign ram.ram_be    = ram_be_q;
  assign ram.ram_addr  = ram_addr_q;
  assign ram.ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_dmem_access.sv
// tb_dmem_access: directed and randomized checks of dmem_access against a
// byte-level reference model of MIPS load/store sizing.
module tb_dmem_access;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic        clk;
  logic        rst;
  logic        memenM;
  logic        memwriteM;
  logic [1:0]  memsizeM;
  logic        memsignM;
  logic [31:0] aluoutM;
  logic [31:0] writedataM;
  logic [31:0] readdataM;
  logic        memstallM;
  logic        adelM;
  logic        adesM;
  logic        buserrM;
  logic [1:0]  dbg_state;

  dmem_access_if ram_bus ();

  dmem_access #(.TIMEOUT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .memenM     (memenM),
    .memwriteM  (memwriteM),
    .memsizeM   (memsizeM),
    .memsignM   (memsignM),
    .aluoutM    (aluoutM),
    .writedataM (writedataM),
    .readdataM  (readdataM),
    .memstallM  (memstallM),
    .adelM      (adelM),
    .adesM      (adesM),
    .buserrM    (buserrM),
    .dbg_state_o(dbg_state),
    .ram        (ram_bus)
  );

  int n_pass = 0;
  int n_total = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_rd;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  function automatic int nbytes_of(input logic [1:0] size);
    return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit model_misaligned(input logic [1:0] size, input logic [31:0] addr);
    return (int'(addr[1:0]) % nbytes_of(size)) != 0;
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] size, input logic [31:0] addr);
    logic [3:0] be;
    int base;
    be = 4'b0000;
    base = int'(addr[1:0]);
    for (int k = 0; k < nbytes_of(size); k++) be[base + k] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] wd);
    logic [31:0] r;
    int n;
    n = nbytes_of(size);
    r = 32'h0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] size, input logic sign,
                                             input logic [31:0] addr, input logic [31:0] rdata);
    logic [31:0] v;
    int n;
    int base;
    n = nbytes_of(size);
    base = int'(addr[1:0]);
    v = 32'h0;
    for (int k = 0; k < n; k++) v[8*k +: 8] = rdata[8*(base + k) +: 8];
    if (n < 4 && sign && v[8*n - 1]) begin
      for (int b = 8*n; b < 32; b++) v[b] = 1'b1;
    end
    return v;
  endfunction

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // ---------------- driver tasks ----------------
  // Called at a falling edge with the DUT in IDLE. Runs one aligned access
  // with the given number of ack wait cycles and returns at a falling edge
  // with the DUT back in IDLE.
  task automatic access(input logic we, input logic [1:0] size, input logic sign,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rdata, input int waits);
    logic [3:0]  ebe;
    logic [31:0] ewd;
    logic [31:0] erd;
    int stalls;
    ebe = model_be(size, addr);
    ewd = model_wdata(size, wd);
    erd = we ? last_rd : model_load(size, sign, addr, rdata);
    exp_q.push_back(erd);
    last_rd = erd;

    memenM = 1'b1; memwriteM = we; memsizeM = size; memsignM = sign;
    aluoutM = addr; writedataM = wd;
    ram_bus.ram_ack = 1'b0; ram_bus.ram_rdata = $urandom;
    #1;
    stalls = memstallM ? 1 : 0;
    chk("issue_state", dbg_state, S_IDLE);
    chk("issue_req_low", ram_bus.ram_req, 1'b0);
    chk("issue_no_adel", adelM, 1'b0);
    chk("issue_no_ades", adesM, 1'b0);

    for (int c = 0; c <= waits; c++) begin
      @(negedge clk);
      ram_bus.ram_ack = (c == waits);
      ram_bus.ram_rdata = (c == waits) ? rdata : $urandom;
      #1;
      if (memstallM) stalls++;
      chk("busy_state", dbg_state, S_BUSY);
      chk("busy_req", ram_bus.ram_req, 1'b1);
      chk("busy_we", ram_bus.ram_we, we);
      chk("busy_be", ram_bus.ram_be, ebe);
      chk("busy_addr", ram_bus.ram_addr, {addr[31:2], 2'b00});
      if (we) chk("busy_wdata", ram_bus.ram_wdata, ewd);
      chk("busy_buserr", buserrM, 1'b0);
    end

    // DONE: drive a misaligned request; it must be ignored entirely.
    @(negedge clk);
    ram_bus.ram_ack = 1'b1;
    memenM = 1'b1; memsizeM = 2'b10; aluoutM = addr | 32'h1;
    #1;
    if (memstallM) stalls++;
    chk("done_state", dbg_state, S_DONE);
    chk("done_stall", memstallM, 1'b0);
    chk("done_readdata", readdataM, exp_q.pop_front());
    chk("done_req", ram_bus.ram_req, 1'b0);
    chk("done_be", ram_bus.ram_be, 4'b0000);
    chk("done_we", ram_bus.ram_we, 1'b0);
    chk("done_no_adel", adelM, 1'b0);
    chk("done_no_ades", adesM, 1'b0);
    chk("stall_cycles", stalls, waits + 2);

    @(negedge clk);
    memenM = 1'b0; ram_bus.ram_ack = 1'b0;
    #1;
    chk("post_idle", dbg_state, S_IDLE);
    chk("post_req", ram_bus.ram_req, 1'b0);
    chk("post_readdata_hold", readdataM, last_rd);
  endtask

  // Misaligned request in IDLE: address error, no request, no stall.
  task automatic misaligned_access(input logic we, input logic [1:0] size, input logic [31:0] addr);
    memenM = 1'b1; memwriteM = we; memsizeM = size; memsignM = 1'b0;
    aluoutM = addr; writedataM = $urandom;
    #1;
    chk("mis_adel", adelM, !we);
    chk("mis_ades", adesM, we);
    chk("mis_stall", memstallM, 1'b0);
    @(negedge clk);
    #1;
    chk("mis_req", ram_bus.ram_req, 1'b0);
    chk("mis_state", dbg_state, S_IDLE);
    memenM = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0]  rsize;
    logic [31:0] raddr;
    int busy;

    rst = 1'b1; memenM = 1'b0; memwriteM = 1'b0; memsizeM = 2'b00; memsignM = 1'b0;
    aluoutM = 32'h0; writedataM = 32'h0;
    ram_bus.ram_ack = 1'b0; ram_bus.ram_rdata = 32'h0;
    last_rd = 32'h0;
    @(negedge clk);
    #1;
    chk("rst_readdata", readdataM, 32'h0);
    chk("rst_req", ram_bus.ram_req, 1'b0);
    chk("rst_we", ram_bus.ram_we, 1'b0);
    chk("rst_be", ram_bus.ram_be, 4'b0000);
    chk("rst_addr", ram_bus.ram_addr, 32'h0);
    chk("rst_wdata", ram_bus.ram_wdata, 32'h0);
    chk("rst_buserr", buserrM, 1'b0);
    chk("rst_state", dbg_state, S_IDLE);
    chk("rst_stall", memstallM, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset during BUSY, then a late ack after release.
    memenM = 1'b1; memwriteM = 1'b0; memsizeM = 2'b10; memsignM = 1'b0; aluoutM = 32'h200;
    @(negedge clk);
    #1;
    chk("rstbusy_req", ram_bus.ram_req, 1'b1);
    memenM = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk("rstbusy_req_drop", ram_bus.ram_req, 1'b0);
    chk("rstbusy_state", dbg_state, S_IDLE);
    @(negedge clk);
    rst = 1'b0;
    ram_bus.ram_ack = 1'b1; ram_bus.ram_rdata = 32'hCAFEF00D;
    @(negedge clk);
    #1;
    chk("late_ack_state", dbg_state, S_IDLE);
    chk("late_ack_req", ram_bus.ram_req, 1'b0);
    chk("late_ack_readdata", readdataM, 32'h0);
    ram_bus.ram_ack = 1'b0;
    @(negedge clk);

    // Directed cases.
    access(1'b0, 2'b10, 1'b0, 32'h104, 32'h0, 32'hDEADBEEF, 0);   // lw
    access(1'b0, 2'b00, 1'b1, 32'h107, 32'h0, 32'h80112233, 0);   // lb
    chk("lb_value", last_rd, 32'hFFFFFF80);
    access(1'b0, 2'b00, 1'b0, 32'h107, 32'h0, 32'h80112233, 1);   // lbu
    chk("lbu_value", last_rd, 32'h00000080);
    access(1'b1, 2'b01, 1'b0, 32'h10A, 32'h0000ABCD, 32'h0, 3);   // sh
    access(1'b0, 2'b01, 1'b1, 32'h10A, 32'h0, 32'h8001_7FFF, 0);  // lh upper lane
    access(1'b0, 2'b11, 1'b1, 32'h110, 32'h0, 32'h1234_5678, 2);  // size 11 acts as word
    misaligned_access(1'b0, 2'b10, 32'h102);                      // lw misaligned
    misaligned_access(1'b1, 2'b01, 32'h101);                      // sh misaligned
    misaligned_access(1'b1, 2'b11, 32'h103);                      // sw (11) misaligned

`ifndef DMEM_TIMEOUT_EN
    // Without the watchdog a long wait must never abort.
    access(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 32'h0BAD_F00D, 20);
`endif

    // Randomized aligned accesses and misaligned attempts.
    for (int i = 0; i < 40; i++) begin
      rsize = 2'($urandom_range(0, 3));
      raddr = $urandom;
      if (rsize == 2'b01) raddr[0] = 1'b0;
      else if (rsize[1]) raddr[1:0] = 2'b00;
      access(1'($urandom_range(0, 1)), rsize, 1'($urandom_range(0, 1)), raddr,
             $urandom, $urandom, $urandom_range(0, 3));
    end
    for (int i = 0; i < 8; i++) begin
      rsize = 2'($urandom_range(1, 3));
      raddr = $urandom;
      if (!model_misaligned(rsize, raddr)) raddr[0] = 1'b1;
      misaligned_access(1'($urandom_range(0, 1)), rsize, raddr);
    end

`ifdef DMEM_TIMEOUT_EN
    // Ack never arrives: abort after TIMEOUT (4) BUSY cycles.
    memenM = 1'b1; memwriteM = 1'b0; memsizeM = 2'b10; memsignM = 1'b0; aluoutM = 32'h300;
    ram_bus.ram_ack = 1'b0;
    busy = 0;
    @(negedge clk);
    #1;
    while (ram_bus.ram_req === 1'b1 && busy < 50) begin
      busy++;
      chk("to_busy_buserr", buserrM, 1'b0);
      chk("to_busy_stall", memstallM, 1'b1);
      @(negedge clk);
      #1;
    end
    chk("to_busy_cycles", busy, 4);
    chk("to_buserr_pulse", buserrM, 1'b1);
    chk("to_readdata", readdataM, 32'h0);
    chk("to_stall_release", memstallM, 1'b0);
    chk("to_state", dbg_state, S_DONE);
    memenM = 1'b0;
    @(negedge clk);
    #1;
    chk("to_buserr_clear", buserrM, 1'b0);
    chk("to_idle", dbg_state, S_IDLE);
    last_rd = 32'h0;
`else
    busy = 0;
    chk("no_watchdog_buserr", buserrM, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
